// File: rtl/add_share_ctrl_pkg.sv
// Shared definitions for the two-requester adder-sharing controller:
// FSM state encoding and requester index constants.
package add_share_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic REQ_ID0 = 1'b0;
  localparam logic REQ_ID1 = 1'b1;

endpackage

// File: rtl/add_share_ctrl_rr_arb2.sv
// Two-way round-robin arbiter, purely combinational. On a tie the requester
// that did not win last time is chosen.
module rr_arb2
  import add_share_ctrl_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  logic       last,
  output logic [1:0] gnt,
  output logic       winner
);

  always_comb begin
    gnt    = 2'b00;
    winner = REQ_ID0;
    if (req0 && req1) begin
      winner = ~last;
    end else if (req1) begin
      winner = REQ_ID1;
    end
    if (req0 || req1) begin
      gnt = (winner == REQ_ID1) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/add_share_ctrl.sv
// Shares one combinational adder between two requesters: arbitrates, holds the
// winner's operands for ADD_CYCLES cycles, then returns the sum with a DONE pulse.
module add_share_ctrl
  import add_share_ctrl_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int ADD_CYCLES = 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             REQ0,
  input  logic [WIDTH-1:0] DATA1_0,
  input  logic [WIDTH-1:0] DATA2_0,
  input  logic             REQ1,
  input  logic [WIDTH-1:0] DATA1_1,
  input  logic [WIDTH-1:0] DATA2_1,
  output logic             GNT0,
  output logic             GNT1,
  output logic             DONE0,
  output logic             DONE1,
  output logic [WIDTH-1:0] RESULT,
  output logic             BUSY,
  output logic [WIDTH-1:0] ADD_DATA1,
  output logic [WIDTH-1:0] ADD_DATA2,
  input  logic [WIDTH-1:0] ADD_RESULT
);

  localparam int CW = (ADD_CYCLES > 1) ? $clog2(ADD_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(ADD_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             last_q, last_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       done_q, done_d;
  logic             busy_d;
  logic [WIDTH-1:0] result_d, add_data1_d, add_data2_d;
  logic [1:0]       arb_gnt;
  logic             arb_winner;

  rr_arb2 u_arb (
    .req0   (REQ0),
    .req1   (REQ1),
    .last   (last_q),
    .gnt    (arb_gnt),
    .winner (arb_winner)
  );

  // last_q doubles as the index of the requester being served while in WAIT.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_q    <= REQ_ID1;
      gnt_q     <= 2'b00;
      done_q    <= 2'b00;
      BUSY      <= 1'b0;
      RESULT    <= '0;
      ADD_DATA1 <= '0;
      ADD_DATA2 <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      BUSY      <= busy_d;
      RESULT    <= result_d;
      ADD_DATA1 <= add_data1_d;
      ADD_DATA2 <= add_data2_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    gnt_d       = 2'b00;
    done_d      = 2'b00;
    result_d    = RESULT;
    add_data1_d = ADD_DATA1;
    add_data2_d = ADD_DATA2;
    case (state_q)
      IDLE: begin
        if (|arb_gnt) begin
          state_d     = WAIT;
          cnt_d       = CNT_INIT;
          last_d      = arb_winner;
          gnt_d       = arb_gnt;
          add_data1_d = (arb_winner == REQ_ID1) ? DATA1_1 : DATA1_0;
          add_data2_d = (arb_winner == REQ_ID1) ? DATA2_1 : DATA2_0;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          result_d       = ADD_RESULT;
          done_d[last_q] = 1'b1;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == WAIT);
  end

  assign GNT0  = gnt_q[0];
  assign GNT1  = gnt_q[1];
  assign DONE0 = done_q[0];
  assign DONE1 = done_q[1];

endmodule

// File: tb/tb_add_share_ctrl.sv
// Bench for add_share_ctrl: two instances (ADD_CYCLES=1 and 3), each with its own
// delayed adder model, checked against a transaction-level round-robin/sum model.
module tb_add_share_ctrl;

  logic       clk;
  logic       rst_n [2];
  logic       req0 [2], req1 [2];
  logic [7:0] d10 [2], d20 [2], d11 [2], d21 [2];
  logic       gnt0 [2], gnt1 [2], done0 [2], done1 [2], busy [2];
  logic [7:0] result [2], add_d1 [2], add_d2 [2], add_res [2];

  int lat [2];
  int mlast [2];
  int checks;
  int errors;

  add_share_ctrl #(.WIDTH(8), .ADD_CYCLES(1)) u_dut1 (
    .CLK(clk), .RESET(rst_n[0]),
    .REQ0(req0[0]), .DATA1_0(d10[0]), .DATA2_0(d20[0]),
    .REQ1(req1[0]), .DATA1_1(d11[0]), .DATA2_1(d21[0]),
    .GNT0(gnt0[0]), .GNT1(gnt1[0]), .DONE0(done0[0]), .DONE1(done1[0]),
    .RESULT(result[0]), .BUSY(busy[0]),
    .ADD_DATA1(add_d1[0]), .ADD_DATA2(add_d2[0]), .ADD_RESULT(add_res[0])
  );

  add_share_ctrl #(.WIDTH(8), .ADD_CYCLES(3)) u_dut3 (
    .CLK(clk), .RESET(rst_n[1]),
    .REQ0(req0[1]), .DATA1_0(d10[1]), .DATA2_0(d20[1]),
    .REQ1(req1[1]), .DATA1_1(d11[1]), .DATA2_1(d21[1]),
    .GNT0(gnt0[1]), .GNT1(gnt1[1]), .DONE0(done0[1]), .DONE1(done1[1]),
    .RESULT(result[1]), .BUSY(busy[1]),
    .ADD_DATA1(add_d1[1]), .ADD_DATA2(add_d2[1]), .ADD_RESULT(add_res[1])
  );

  // Shared combinational adders with a 2-unit propagation delay.
  assign #2 add_res[0] = add_d1[0] + add_d2[0];
  assign #2 add_res[1] = add_d1[1] + add_d2[1];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input bit r0, input bit r1, input int last);
    if (r0 && r1) return (last == 1) ? 0 : 1;
    return r0 ? 0 : 1;
  endfunction

  task automatic scramble(input int d);
    d10[d] = 8'($urandom);
    d20[d] = 8'($urandom);
    d11[d] = 8'($urandom);
    d21[d] = 8'($urandom);
  endtask

  task automatic reset_dut(input int d);
    rst_n[d] = 1'b0;
    req0[d] = 1'($urandom);
    req1[d] = 1'($urandom);
    scramble(d);
    #2;
    check($sformatf("rst%0d_gnt0", d), gnt0[d], 0);
    check($sformatf("rst%0d_gnt1", d), gnt1[d], 0);
    check($sformatf("rst%0d_done0", d), done0[d], 0);
    check($sformatf("rst%0d_done1", d), done1[d], 0);
    check($sformatf("rst%0d_busy", d), busy[d], 0);
    check($sformatf("rst%0d_result", d), result[d], 0);
    check($sformatf("rst%0d_add1", d), add_d1[d], 0);
    check($sformatf("rst%0d_add2", d), add_d2[d], 0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      req0[d] = 1'($urandom);
      req1[d] = 1'($urandom);
      check($sformatf("rst%0d_hold_busy", d), busy[d], 0);
      check($sformatf("rst%0d_hold_gnt", d), {gnt0[d], gnt1[d]}, 0);
    end
    req0[d] = 1'b0;
    req1[d] = 1'b0;
    rst_n[d] = 1'b1;
    mlast[d] = 1;
  endtask

  task automatic idle_cycle(input int d);
    req0[d] = 1'b0;
    req1[d] = 1'b0;
    @(posedge clk);
    #1;
    check($sformatf("idle%0d_gnt", d), {gnt0[d], gnt1[d]}, 0);
    check($sformatf("idle%0d_done", d), {done0[d], done1[d]}, 0);
    check($sformatf("idle%0d_busy", d), busy[d], 0);
  endtask

  task automatic run_op(input int d, input bit r0, input bit r1,
                        input logic [7:0] a0, input logic [7:0] b0,
                        input logic [7:0] a1, input logic [7:0] b1, input bit hold);
    int w;
    int sum;
    w   = pick(r0, r1, mlast[d]);
    sum = (w == 0) ? (int'(a0) + int'(b0)) % 256 : (int'(a1) + int'(b1)) % 256;
    req0[d] = r0;
    req1[d] = r1;
    d10[d] = a0; d20[d] = b0; d11[d] = a1; d21[d] = b1;
    @(posedge clk);
    #1;
    check($sformatf("op%0d_gnt0", d), gnt0[d], (w == 0));
    check($sformatf("op%0d_gnt1", d), gnt1[d], (w == 1));
    check($sformatf("op%0d_busy_grant", d), busy[d], 1);
    mlast[d] = w;
    scramble(d);
    if (!hold) begin
      req0[d] = 1'b0;
      req1[d] = 1'b0;
    end
    for (int k = 1; k <= lat[d]; k++) begin
      @(posedge clk);
      #1;
      if (k < lat[d]) begin
        check($sformatf("op%0d_wait_busy", d), busy[d], 1);
        check($sformatf("op%0d_wait_gnt", d), {gnt0[d], gnt1[d]}, 0);
        check($sformatf("op%0d_wait_done", d), {done0[d], done1[d]}, 0);
      end else begin
        check($sformatf("op%0d_done0", d), done0[d], (w == 0));
        check($sformatf("op%0d_done1", d), done1[d], (w == 1));
        check($sformatf("op%0d_result", d), result[d], sum);
        check($sformatf("op%0d_busy_done", d), busy[d], 0);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    lat[0] = 1;
    lat[1] = 3;
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0;
      req0[d] = 1'b0;
      req1[d] = 1'b0;
      mlast[d] = 1;
      scramble(d);
    end
    @(posedge clk);
    #1;
    reset_dut(0);
    reset_dut(1);

    // Single-cycle instance: basic add, tie alternation, wrap.
    run_op(0, 1, 0, 8'd5, 8'd3, 8'd0, 8'd0, 0);
    idle_cycle(0);
    for (int i = 0; i < 4; i++) run_op(0, 1, 1, 8'd10, 8'd20, 8'd1, 8'd2, 1);
    idle_cycle(0);
    run_op(0, 0, 1, 8'd0, 8'd0, 8'd200, 8'd100, 0);
    idle_cycle(0);

    // Three-cycle instance: latency, then reset in the second WAIT cycle.
    run_op(1, 1, 0, 8'd7, 8'd9, 8'd0, 8'd0, 0);
    idle_cycle(1);
    req0[1] = 1'b1;
    d10[1] = 8'd50;
    d20[1] = 8'd60;
    @(posedge clk);
    #1;
    check("midrst_gnt0", gnt0[1], 1);
    req0[1] = 1'b0;
    @(posedge clk);
    #1;
    rst_n[1] = 1'b0;
    #1;
    check("midrst_busy", busy[1], 0);
    check("midrst_result", result[1], 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("midrst_nodone", {done0[1], done1[1]}, 0);
    end
    rst_n[1] = 1'b1;
    mlast[1] = 1;
    @(posedge clk);
    #1;
    check("midrst_after_done", {done0[1], done1[1]}, 0);
    check("midrst_after_result", result[1], 0);
    run_op(1, 1, 1, 8'd4, 8'd4, 8'd9, 8'd9, 0);

    // Randomized traffic on both instances.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 25; i++) begin
        int r;
        r = int'($urandom_range(1, 3));
        run_op(d, r[0], r[1], 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
               1'($urandom));
        if ($urandom_range(0, 3) == 0) idle_cycle(d);
      end
      idle_cycle(d);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
